jzjpcc_ex_mem_stage: RTL and testbench

Parametrised execute-to-memory pipeline stage for the JZJ pipelined core. It replaces the bare execute/memory signal bundle with a registered, flow-controlled stage. The stage is a 2-entry skid buffer with valid/ready handshakes on both sides, and it supports flush. It generates byte/half/word(/doubleword) byte-lane masks and replicated store data, so the memory stage receives aligned lanes. It sits between the execute stage and the data-memory port.

---
 rtl/jzjpcc_pkg.sv | 30 +++
 rtl/jzjpcc_store_align.sv | 64 ++++++
 rtl/jzjpcc_ex_mem_stage.sv | 148 ++++++++++++++
 tb/tb_jzjpcc_ex_mem_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jzjpcc_pkg.sv
// Shared types for the JZJ pipelined core EX/MEM stage.
// Optional build macro: JZJPCC_MISALIGN_TRAP_EN (see jzjpcc_store_align).
package jzjpcc_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'b00,
        HALF  = 2'b01,
        WORD  = 2'b10,
        DWORD = 2'b11
    } mem_size_t;

    typedef enum logic {
        ALU_RESULT = 1'b0,
        MEMORY_OUT = 1'b1
    } rd_source_t;

    // Control half of a buffered entry; the XLEN-wide fields live beside it.
    typedef struct packed {
        logic       mem_write;
        rd_source_t rd_source;
        logic       rd_write;
        logic       misaligned;
    } entry_ctrl_t;

    // A 32-bit core has no doubleword access; it degrades to a word.
    function automatic mem_size_t eff_size(input mem_size_t s, input int xlen);
        return (xlen == 32 && s == DWORD) ? WORD : s;
    endfunction

endpackage

// File: rtl/jzjpcc_store_align.sv
// Size/offset -> byte-lane mask, lane-replicated store data, misalignment flag.
// JZJPCC_MISALIGN_TRAP_EN enables the misaligned flag; otherwise it is tied 0.
module jzjpcc_store_align
    import jzjpcc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]                   i_size,
    input  logic [$clog2(XLEN/8)-1:0]    i_offset,
    input  logic [XLEN-1:0]              i_data,
    output logic [XLEN/8-1:0]            o_mask,
    output logic [XLEN-1:0]              o_wdata,
    output logic                         o_misaligned
);
    localparam int LANES    = XLEN / 8;
    localparam int ADDR_LSB = $clog2(LANES);

    mem_size_t             w_size;
    logic [ADDR_LSB-1:0]   w_half_off;
    logic [ADDR_LSB-1:0]   w_word_off;

    assign w_size     = eff_size(mem_size_t'(i_size), XLEN);
    // Lanes always snap down to the access size, so the mask never straddles.
    assign w_half_off = i_offset & ~ADDR_LSB'(1);
    assign w_word_off = i_offset & ~ADDR_LSB'(3);

    always_comb begin
        o_mask  = '1;
        o_wdata = i_data;
        case (w_size)
            BYTE: begin
                o_mask  = LANES'(1) << i_offset;
                o_wdata = {LANES{i_data[7:0]}};
            end
            HALF: begin
                o_mask  = LANES'(3) << w_half_off;
                o_wdata = {(LANES/2){i_data[15:0]}};
            end
            WORD: begin
                o_mask  = LANES'(15) << w_word_off;
                o_wdata = {(LANES/4){i_data[31:0]}};
            end
            default: begin
                o_mask  = '1;
                o_wdata = i_data;
            end
        endcase
    end

`ifdef JZJPCC_MISALIGN_TRAP_EN
    always_comb begin
        o_misaligned = 1'b0;
        case (w_size)
            HALF:    o_misaligned = i_offset[0];
            WORD:    o_misaligned = |i_offset[1:0];
            DWORD:   o_misaligned = |i_offset;
            default: o_misaligned = 1'b0;
        endcase
    end
`else
    assign o_misaligned = 1'b0;
`endif

endmodule

// File: rtl/jzjpcc_ex_mem_stage.sv
// EX->MEM 2-entry skid buffer (head H + skid S) with flush and lane alignment.
// JZJPCC_MISALIGN_TRAP_EN: flag misaligned accesses and suppress their stores.
module jzjpcc_ex_mem_stage
    import jzjpcc_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RD_ADDR_W = 5
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              flush,
    input  logic                              ex_valid,
    output logic                              ex_ready,
    input  logic [XLEN-1:0]                   ex_alu_result,
    input  logic [XLEN-1:0]                   ex_store_data,
    input  logic [RD_ADDR_W-1:0]              ex_rd_addr,
    input  logic [1:0]                        ex_mem_size,
    input  logic                              ex_mem_read,
    input  logic                              ex_mem_write,
    input  logic                              ex_rd_write,
    output logic                              mem_valid,
    input  logic                              mem_ready,
    output logic [XLEN-$clog2(XLEN/8)-1:0]    mem_word_addr,
    output logic [XLEN/8-1:0]                 mem_byte_mask,
    output logic [XLEN-1:0]                   mem_write_data,
    output logic                              mem_write_en,
    output logic [XLEN-1:0]                   mem_alu_result,
    output logic [RD_ADDR_W-1:0]              mem_rd_addr,
    output logic                              mem_rd_source,
    output logic                              mem_rd_write,
    output logic                              mem_misaligned
);
    localparam int LANES    = XLEN / 8;
    localparam int ADDR_LSB = $clog2(LANES);

    logic [LANES-1:0]       w_mask;
    logic [LANES-1:0]       w_new_mask;
    logic [XLEN-1:0]        w_new_wdata;
    logic                   w_mis;
    entry_ctrl_t            w_new_ctrl;

    logic                   r_h_vld, r_s_vld, r_ex_ready;
    logic [XLEN-1:0]        r_h_alu, r_s_alu, r_h_wdata, r_s_wdata;
    logic [LANES-1:0]       r_h_mask, r_s_mask;
    logic [RD_ADDR_W-1:0]   r_h_rd, r_s_rd;
    entry_ctrl_t            r_h_ctrl, r_s_ctrl;

    logic w_acc, w_pop, w_h_from_s, w_h_from_ex, w_s_from_ex;
    logic w_h_vld_nxt, w_s_vld_nxt;

    jzjpcc_store_align #(.XLEN(XLEN)) u_align (
        .i_size       (ex_mem_size),
        .i_offset     (ex_alu_result[ADDR_LSB-1:0]),
        .i_data       (ex_store_data),
        .o_mask       (w_mask),
        .o_wdata      (w_new_wdata),
        .o_misaligned (w_mis)
    );

    // Non-memory ops still travel for writeback but touch no lanes.
    assign w_new_mask           = (ex_mem_read || ex_mem_write) ? w_mask : '0;
    assign w_new_ctrl.mem_write  = ex_mem_write;
    assign w_new_ctrl.rd_source  = rd_source_t'(ex_mem_read);
    assign w_new_ctrl.rd_write   = ex_rd_write;
    assign w_new_ctrl.misaligned = w_mis;

    assign w_acc       = ex_valid && r_ex_ready;
    assign w_pop       = r_h_vld && mem_ready;
    assign w_h_from_s  = w_pop && r_s_vld;
    assign w_h_from_ex = w_acc && (!r_h_vld || (w_pop && !r_s_vld));
    assign w_s_from_ex = w_acc && !w_h_from_ex;

    always_comb begin
        w_h_vld_nxt = r_h_vld;
        w_s_vld_nxt = r_s_vld;
        if (flush) begin
            w_h_vld_nxt = 1'b0;
            w_s_vld_nxt = 1'b0;
        end else begin
            if (w_h_from_s || w_h_from_ex) w_h_vld_nxt = 1'b1;
            else if (w_pop)                w_h_vld_nxt = 1'b0;
            if (w_s_from_ex)               w_s_vld_nxt = 1'b1;
            else if (w_h_from_s)           w_s_vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_h_vld    <= 1'b0;
            r_s_vld    <= 1'b0;
            r_ex_ready <= 1'b1;
        end else begin
            r_h_vld    <= w_h_vld_nxt;
            r_s_vld    <= w_s_vld_nxt;
            r_ex_ready <= !w_s_vld_nxt;
        end
    end

    // Payload needs no flush gating: the valid bits already discard it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_h_alu   <= '0;
            r_h_wdata <= '0;
            r_h_mask  <= '0;
            r_h_rd    <= '0;
            r_h_ctrl  <= '0;
            r_s_alu   <= '0;
            r_s_wdata <= '0;
            r_s_mask  <= '0;
            r_s_rd    <= '0;
            r_s_ctrl  <= '0;
        end else begin
            if (w_h_from_s) begin
                r_h_alu   <= r_s_alu;
                r_h_wdata <= r_s_wdata;
                r_h_mask  <= r_s_mask;
                r_h_rd    <= r_s_rd;
                r_h_ctrl  <= r_s_ctrl;
            end else if (w_h_from_ex) begin
                r_h_alu   <= ex_alu_result;
                r_h_wdata <= w_new_wdata;
                r_h_mask  <= w_new_mask;
                r_h_rd    <= ex_rd_addr;
                r_h_ctrl  <= w_new_ctrl;
            end
            if (w_s_from_ex) begin
                r_s_alu   <= ex_alu_result;
                r_s_wdata <= w_new_wdata;
                r_s_mask  <= w_new_mask;
                r_s_rd    <= ex_rd_addr;
                r_s_ctrl  <= w_new_ctrl;
            end
        end
    end

    assign ex_ready       = r_ex_ready;
    assign mem_valid      = r_h_vld;
    assign mem_word_addr  = r_h_alu[XLEN-1:ADDR_LSB];
    assign mem_byte_mask  = r_h_mask;
    assign mem_write_data = r_h_wdata;
    assign mem_write_en   = r_h_vld && r_h_ctrl.mem_write && !r_h_ctrl.misaligned;
    assign mem_alu_result = r_h_alu;
    assign mem_rd_addr    = r_h_rd;
    assign mem_rd_source  = r_h_ctrl.rd_source;
    assign mem_rd_write   = r_h_ctrl.rd_write;
    assign mem_misaligned = r_h_ctrl.misaligned;

endmodule

// File: tb/tb_jzjpcc_ex_mem_stage.sv
// Self-checking bench: directed spec cases plus randomized traffic vs a queue model.
module tb_jzjpcc_ex_mem_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush, ex_valid, ex_ready, mem_valid, mem_ready;
    logic [31:0] ex_alu_result, ex_store_data, mem_write_data, mem_alu_result;
    logic [4:0]  ex_rd_addr, mem_rd_addr;
    logic [1:0]  ex_mem_size;
    logic        ex_mem_read, ex_mem_write, ex_rd_write;
    logic [29:0] mem_word_addr;
    logic [3:0]  mem_byte_mask;
    logic        mem_write_en, mem_rd_source, mem_rd_write, mem_misaligned;

    logic        d_flush, d_ex_valid, d_ex_ready, d_mem_valid, d_mem_ready;
    logic [63:0] d_ex_alu_result, d_ex_store_data, d_mem_write_data, d_mem_alu_result;
    logic [4:0]  d_ex_rd_addr, d_mem_rd_addr;
    logic [1:0]  d_ex_mem_size;
    logic        d_ex_mem_read, d_ex_mem_write, d_ex_rd_write;
    logic [60:0] d_mem_word_addr;
    logic [7:0]  d_mem_byte_mask;
    logic        d_mem_write_en, d_mem_rd_source, d_mem_rd_write, d_mem_misaligned;

    always #5 clock = ~clock;

    jzjpcc_ex_mem_stage #(.XLEN(32), .RD_ADDR_W(5)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_rd_addr(ex_rd_addr), .ex_mem_size(ex_mem_size),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_rd_write(ex_rd_write),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_word_addr(mem_word_addr), .mem_byte_mask(mem_byte_mask),
        .mem_write_data(mem_write_data), .mem_write_en(mem_write_en),
        .mem_alu_result(mem_alu_result), .mem_rd_addr(mem_rd_addr),
        .mem_rd_source(mem_rd_source), .mem_rd_write(mem_rd_write),
        .mem_misaligned(mem_misaligned)
    );

    jzjpcc_ex_mem_stage #(.XLEN(64), .RD_ADDR_W(5)) dut64 (
        .clock(clock), .reset_n(reset_n), .flush(d_flush),
        .ex_valid(d_ex_valid), .ex_ready(d_ex_ready),
        .ex_alu_result(d_ex_alu_result), .ex_store_data(d_ex_store_data),
        .ex_rd_addr(d_ex_rd_addr), .ex_mem_size(d_ex_mem_size),
        .ex_mem_read(d_ex_mem_read), .ex_mem_write(d_ex_mem_write), .ex_rd_write(d_ex_rd_write),
        .mem_valid(d_mem_valid), .mem_ready(d_mem_ready),
        .mem_word_addr(d_mem_word_addr), .mem_byte_mask(d_mem_byte_mask),
        .mem_write_data(d_mem_write_data), .mem_write_en(d_mem_write_en),
        .mem_alu_result(d_mem_alu_result), .mem_rd_addr(d_mem_rd_addr),
        .mem_rd_source(d_mem_rd_source), .mem_rd_write(d_mem_rd_write),
        .mem_misaligned(d_mem_misaligned)
    );

    typedef struct packed {
        logic [29:0] waddr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        src, rdw, wen, mis;
    } pkt_t;

    pkt_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Expected head contents derived straight from the access-size rules.
    function automatic pkt_t mk_pkt(input logic [31:0] addr, input logic [31:0] data,
                                    input logic [1:0] sz, input logic [4:0] rd,
                                    input logic rdd, input logic wr, input logic rdw);
        pkt_t p;
        int nb, off, base;
        nb   = 1 << ((sz == 2'd3) ? 2 : int'(sz));
        off  = int'(addr % 4);
        base = off - (off % nb);
        p.mask = (rdd || wr) ? 4'(((1 << nb) - 1) << base) : 4'h0;
        for (int i = 0; i < 4; i++) p.wdata[i*8 +: 8] = data[(i % nb)*8 +: 8];
`ifdef JZJPCC_MISALIGN_TRAP_EN
        p.mis = (off % nb) != 0;
`else
        p.mis = 1'b0;
`endif
        p.wen   = wr && !p.mis;
        p.waddr = 30'(addr / 4);
        p.alu   = addr;
        p.rd    = rd;
        p.src   = rdd;
        p.rdw   = rdw;
        return p;
    endfunction

    task automatic check_model();
        chk("mem_valid", mem_valid, q.size() > 0);
        chk("ex_ready", ex_ready, q.size() < 2);
        if (q.size() > 0) begin
            chk("word_addr", mem_word_addr, q[0].waddr);
            chk("byte_mask", mem_byte_mask, q[0].mask);
            chk("write_data", mem_write_data, q[0].wdata);
            chk("write_en", mem_write_en, q[0].wen);
            chk("alu_result", mem_alu_result, q[0].alu);
            chk("rd_addr", mem_rd_addr, q[0].rd);
            chk("rd_source", mem_rd_source, q[0].src);
            chk("rd_write", mem_rd_write, q[0].rdw);
            chk("misaligned", mem_misaligned, q[0].mis);
        end
    endtask

    // Inputs are already driven; advance one edge and compare against the model.
    task automatic step(output bit acc);
        bit   pop;
        pkt_t p;
        acc = ex_valid && (q.size() < 2);
        pop = mem_ready && (q.size() > 0);
        p   = mk_pkt(ex_alu_result, ex_store_data, ex_mem_size, ex_rd_addr,
                     ex_mem_read, ex_mem_write, ex_rd_write);
        @(posedge clock);
        if (flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(p);
        end
        @(negedge clock);
        check_model();
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                          input logic [4:0] rd, input logic r, input logic w, input logic rw);
        ex_alu_result = a; ex_store_data = d; ex_mem_size = sz; ex_rd_addr = rd;
        ex_mem_read = r; ex_mem_write = w; ex_rd_write = rw;
    endtask

    task automatic rand_op();
        set_op($urandom, $urandom, 2'($urandom_range(0, 3)), 5'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom));
    endtask

    task automatic d_op(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz);
        d_ex_alu_result = a; d_ex_store_data = d; d_ex_mem_size = sz; d_ex_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        d_ex_valid = 1'b0;
    endtask

    initial begin
        bit a;
        int nacc, cyc;
        reset_n = 1'b0; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b1;
        set_op('0, '0, 2'd0, '0, 1'b0, 1'b0, 1'b0);
        d_flush = 1'b0; d_ex_valid = 1'b0; d_mem_ready = 1'b1;
        d_ex_alu_result = '0; d_ex_store_data = '0; d_ex_rd_addr = '0; d_ex_mem_size = '0;
        d_ex_mem_read = 1'b0; d_ex_mem_write = 1'b1; d_ex_rd_write = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_valid", mem_valid, 1'b0);
        chk("rst_ready", ex_ready, 1'b1);
        chk("rst_mask", mem_byte_mask, 4'h0);
        chk("rst_wdata", mem_write_data, 32'h0);
        chk("rst_waddr", mem_word_addr, 30'h0);
        chk("rst_wen", mem_write_en, 1'b0);
        chk("rst_ready64", d_ex_ready, 1'b1);
        reset_n = 1'b1;
        @(negedge clock);

        // byte store 0x1003
        ex_valid = 1'b1;
        set_op(32'h1003, 32'hAB, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(a);
        chk("byte_valid", mem_valid, 1'b1);
        chk("byte_mask", mem_byte_mask, 4'b1000);
        chk("byte_wdata", mem_write_data, 32'hABABABAB);
        chk("byte_waddr", mem_word_addr, 30'h400);
        chk("byte_wen", mem_write_en, 1'b1);

        // half store 0x2001
        set_op(32'h2001, 32'hBEEF, 2'd1, 5'd0, 1'b0, 1'b1, 1'b0);
        step(a);
`ifdef JZJPCC_MISALIGN_TRAP_EN
        chk("half_mis", mem_misaligned, 1'b1);
        chk("half_wen", mem_write_en, 1'b0);
`else
        chk("half_mask", mem_byte_mask, 4'b0011);
        chk("half_wen", mem_write_en, 1'b1);
`endif

        // load word 0x10 -> rd 5
        set_op(32'h10, 32'h0, 2'd2, 5'd5, 1'b1, 1'b0, 1'b1);
        step(a);
        chk("ld_src", mem_rd_source, 1'b1);
        chk("ld_rdw", mem_rd_write, 1'b1);
        chk("ld_mask", mem_byte_mask, 4'hF);
        chk("ld_wen", mem_write_en, 1'b0);
        ex_valid = 1'b0;
        step(a);

        // back-pressure: 4 ops, mem_ready low for 3 cycles
        nacc = 0; cyc = 0;
        ex_valid = 1'b1;
        rand_op();
        while (nacc < 4 && cyc < 40) begin
            mem_ready = (cyc >= 3);
            step(a);
            if (a) begin
                nacc++;
                if (nacc == 2) chk("bp_ready_low", ex_ready, 1'b0);
                rand_op();
            end
            cyc++;
        end
        chk("bp_accepts", nacc, 4);
        ex_valid = 1'b0; mem_ready = 1'b1;
        repeat (4) step(a);
        chk("bp_drained", mem_valid, 1'b0);

        // flush with both entries full and a new op offered
        mem_ready = 1'b0; ex_valid = 1'b1;
        rand_op(); step(a);
        rand_op(); step(a);
        flush = 1'b1; rand_op(); step(a);
        chk("flush_valid", mem_valid, 1'b0);
        chk("flush_ready", ex_ready, 1'b1);
        flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b1;
        step(a);

        // asynchronous reset mid-transfer
        mem_ready = 1'b0; ex_valid = 1'b1;
        rand_op(); step(a);
        rand_op(); step(a);
        ex_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", mem_valid, 1'b0);
        chk("arst_ready", ex_ready, 1'b1);
        q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        mem_ready = 1'b1;
        step(a);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            ex_valid  = ($urandom_range(0, 9) < 7);
            mem_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 3);
            rand_op();
            step(a);
        end
        flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b1;
        repeat (3) step(a);

        // XLEN=64 lane checks
        d_op(64'h1004, 64'h12345678, 2'd2);
        chk("d_word_mask", d_mem_byte_mask, 8'hF0);
        chk("d_word_wdata", d_mem_write_data, 64'h1234567812345678);
        chk("d_word_waddr", d_mem_word_addr, 61'h200);
        chk("d_word_wen", d_mem_write_en, 1'b1);
        d_op(64'h8, 64'h1122334455667788, 2'd3);
        chk("d_dw_mask", d_mem_byte_mask, 8'hFF);
        chk("d_dw_wdata", d_mem_write_data, 64'h1122334455667788);
        d_op(64'h5, 64'h5A, 2'd0);
        chk("d_byte_mask", d_mem_byte_mask, 8'h20);
        chk("d_byte_wdata", d_mem_write_data, 64'h5A5A5A5A5A5A5A5A);
        d_op(64'h6, 64'hC0DE, 2'd1);
        chk("d_half_mask", d_mem_byte_mask, 8'hC0);
        chk("d_half_wdata", d_mem_write_data, 64'hC0DEC0DEC0DEC0DE);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
